// File: rtl/mult_div_unit.sv
// Multi-cycle radix-2 multiply/divide unit with HI/LO registers.
// One shift-add or restoring-subtract step per cycle, signed or unsigned.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic             unsign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     opnd;
  logic                 is_div;
  logic                 neg_p;
  logic                 neg_r;
  logic                 dz;

  logic                 sa;
  logic                 sb;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       shl;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   step;
  logic [2*WIDTH-1:0]   sprod;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     fin_hi;
  logic [WIDTH-1:0]     fin_lo;

  always_comb begin
    sa    = ~unsign & a[WIDTH-1];
    sb    = ~unsign & b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
  end

  // Divide keeps {remainder, dividend/quotient} in prod; borrow is diff[WIDTH].
  always_comb begin
    add_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    shl     = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    diff    = shl - {1'b0, opnd};
    step    = prod;
    if (is_div) begin
      if (diff[WIDTH])
        step = {shl[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
      else
        step = {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
    end else begin
      if (prod[0])
        step = {add_sum, prod[WIDTH-1:1]};
      else
        step = {1'b0, prod[2*WIDTH-1:1]};
    end
  end

  always_comb begin
    sprod  = neg_p ? -prod : prod;
    quo    = prod[WIDTH-1:0];
    rem    = prod[2*WIDTH-1:WIDTH];
    fin_lo = is_div ? (neg_p ? -quo : quo) : sprod[WIDTH-1:0];
    fin_hi = is_div ? (neg_r ? -rem : rem) : sprod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      prod        <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      neg_p       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= op_div;
            prod   <= {{WIDTH{1'b0}}, op_div ? mag_a : mag_b};
            opnd   <= op_div ? mag_b : mag_a;
            neg_p  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= op_div & (b == '0);
          end else begin
            if (hi_wr) hi <= wr_data;
            if (lo_wr) lo <= wr_data;
          end
        end
        CALC: begin
          prod <= step;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= FINISH;
        end
        FINISH: begin
          state       <= IDLE;
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= dz;
          if (!dz) begin
            hi <= fin_hi;
            lo <= fin_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit against a plain-arithmetic model.
// Directed corner cases plus randomized mul/div/MT traffic.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op_div;
  logic        unsign;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .op_div(op_div), .unsign(unsign), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic exp_t model(bit dv, bit us,
                                 logic [31:0] xa, logic [31:0] xb);
    exp_t        e;
    logic [63:0] p;
    longint      sx, sy, q, r;
    sx = longint'($signed(xa));
    sy = longint'($signed(xb));
    e.dz = 0;
    e.hi = m_hi;
    e.lo = m_lo;
    if (!dv) begin
      if (us) p = {32'd0, xa} * {32'd0, xb};
      else    p = 64'(sx * sy);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (xb == 0) begin
      e.dz = 1;
    end else if (us) begin
      e.lo = xa / xb;
      e.hi = xa % xb;
    end else begin
      q = sx / sy;
      r = sx % sy;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end
    m_hi = e.hi;
    m_lo = e.lo;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding op.
  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected hi=%h lo=%h", hi, lo);
      end else begin
        e = sbq.pop_front();
        if (hi !== e.hi || lo !== e.lo || div_by_zero !== e.dz) begin
          errors++;
          $display("FAIL result got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=%b",
                   hi, lo, div_by_zero, e.hi, e.lo, e.dz);
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns just after accept edge.
  task automatic launch(bit dv, bit us, logic [31:0] xa,
                        logic [31:0] xb, bit wr_too);
    start   = 1;
    op_div  = dv;
    unsign  = us;
    a       = xa;
    b       = xb;
    hi_wr   = wr_too;
    lo_wr   = wr_too;
    wr_data = 32'hDEAD_BEEF;
    @(posedge clk);
    sbq.push_back(model(dv, us, xa, xb));
    #1;
    start = 0;
    hi_wr = 0;
    lo_wr = 0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Returns at the negedge where done is seen; n counts busy cycles.
  task automatic wait_done(output int n);
    bit got;
    n   = 0;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
      else if (busy) n++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout busy_cycles=%0d", n);
    end
  endtask

  task automatic mt_write(bit wh, bit wl, logic [31:0] d);
    @(negedge clk);
    hi_wr   = wh;
    lo_wr   = wl;
    wr_data = d;
    @(posedge clk);
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    #1;
    hi_wr = 0;
    lo_wr = 0;
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] c;
    case ($urandom_range(0, 7))
      0: c = 32'h0;
      1: c = 32'h1;
      2: c = 32'hFFFF_FFFF;
      3: c = 32'h8000_0000;
      4: c = 32'h7FFF_FFFF;
      5: c = 32'($urandom_range(0, 20));
      default: c = $urandom;
    endcase
    return c;
  endfunction

  initial begin
    int n;
    reset   = 1;
    start   = 0;
    op_div  = 0;
    unsign  = 0;
    a       = 0;
    b       = 0;
    hi_wr   = 0;
    lo_wr   = 0;
    wr_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dz", 32'(div_by_zero), 0);
    @(negedge clk);
    reset = 0;

    @(negedge clk);
    launch(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    wait_done(n);
    chk("busy_window", 32'(n), 33);

    // Back-to-back issue in the done cycle.
    launch(0, 0, -32'sd3, 32'd7, 0);
    wait_done(n);
    chk("b2b_busy", 32'(n), 33);
    launch(0, 0, 32'h8000_0000, 32'h8000_0000, 0);
    wait_done(n);
    launch(1, 0, -32'sd7, 32'd2, 0);
    wait_done(n);
    launch(1, 1, 32'hFFFF_FFF9, 32'd2, 0);
    wait_done(n);
    launch(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    wait_done(n);

    mt_write(1, 0, 32'h11);
    mt_write(0, 1, 32'h22);
    @(negedge clk);
    launch(1, 0, 32'd5, 32'd0, 0);
    wait_done(n);
    chk("dz_busy", 32'(n), 33);

    // Write coincident with start must be dropped.
    launch(1, 1, 32'd9, 32'd0, 1);
    wait_done(n);

    // Start mid-CALC with other operands is ignored.
    launch(0, 1, 32'd1234, 32'd5678, 0);
    repeat (5) @(negedge clk);
    start  = 1;
    op_div = 1;
    a      = 32'd99;
    b      = 32'd3;
    @(negedge clk);
    start = 0;
    wait_done(n);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 5) == 0)
        mt_write(1'($urandom), 1'($urandom), $urandom);
      @(negedge clk);
      launch(1'($urandom), 1'($urandom), pick(), pick(), 1'($urandom));
      wait_done(n);
    end

    // Reset 10 cycles into a multiply aborts it silently.
    @(negedge clk);
    launch(0, 1, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    repeat (10) @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    sbq.delete();
    m_hi = 0;
    m_lo = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(negedge clk);
    reset = 0;
    repeat (40) @(negedge clk);

    launch(0, 0, 32'hFFFF_FFF0, 32'd3, 0);
    wait_done(n);
    chk("post_rst_busy", 32'(n), 33);
    @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
